lynx_mem_map: RTL and testbench

LYNX_MEM_MAP -- requirements
Module: lynx_mem_map

---
 rtl/lynx_mem_map.sv | 187 ++++++++++++++++++
 tb/tb_lynx_mem_map.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lynx_mem_map.sv
// Lynx memory map: CPU address translation, I/O port registers 7F/80/FF, and a
// cycle-stealing DMA path that writes tape-loader bytes into RAM.
module lynx_mem_map #(
    parameter int BANKS     = 4,
    parameter int STALL_MAX = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cep,
    input  logic [15:0]                  a,
    input  logic [7:0]                   cpu_do,
    input  logic                         mreq,
    input  logic                         iorq,
    input  logic                         wr,
    input  logic [1:0]                   mode,
    input  logic                         dma_valid,
    input  logic [15:0]                  dma_addr,
    input  logic [7:0]                   dma_data,
    output logic                         dma_ready,
    input  logic                         dma_last,
    output logic                         wait_n,
    output logic [16+$clog2(BANKS)-3:0]  ram_a,
    output logic [7:0]                   ram_di,
    output logic                         ram_we,
    output logic [7:0]                   reg7f,
    output logic [5:1]                   reg80,
    output logic [$clog2(BANKS)-1:0]     bank,
    output logic                         rom_cs,
    output logic [15:0]                  dir,
    output logic                         dirset
);

    localparam int BW  = $clog2(BANKS);
    localparam int RAW = 14 + BW;
    localparam int CW  = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [CW-1:0] STALL_LIM = CW'(STALL_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PEND  = 3'd1,
        S_STEAL = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } dma_state_t;

    dma_state_t      state_r, state_s;
    logic [CW-1:0]   stall_cnt_r;
    logic [15:0]     cap_addr_r;
    logic [7:0]      cap_data_r;
    logic            cap_last_r;
    logic            port_wr_s, port7f_s, port80_s, portff_s, cpu_wr_s;
    logic [RAW-1:0]  cpu_ram_a_s;

    assign port_wr_s = !iorq && !wr;
    assign port7f_s  = port_wr_s && (a[6:0] == 7'h7f);
    assign port80_s  = port_wr_s && a[7] && !a[6] && !a[2] && !a[1];
    assign portff_s  = port_wr_s && (a[7:0] == 8'hff);
    assign cpu_wr_s  = !mreq && !wr && !reg7f[0];
    assign rom_cs    = !mreq && !reg7f[4] &&
                       ((a[15:14] == 2'b00) || ((a[15:13] == 3'b010) && (mode != 2'd0)));
    assign wait_n    = reset || (state_r != S_STEAL);

    // DMA state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else if (cep) begin
            state_r <= state_s;
        end
    end

    // DMA next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  if (dma_valid) state_s = S_PEND; else state_s = S_IDLE;
            S_PEND: begin
                if (mreq) begin
                    state_s = S_WRITE;
                end else if (stall_cnt_r == STALL_LIM) begin
                    state_s = S_STEAL;
                end else begin
                    state_s = S_PEND;
                end
            end
            S_STEAL: state_s = S_WRITE;
            S_WRITE: if (cap_last_r) state_s = S_DONE; else state_s = S_IDLE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Stall counter: counts ceps the CPU keeps the bus while a byte is pending
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (cep) begin
            if (state_r == S_WRITE) begin
                stall_cnt_r <= '0;
            end else if ((state_r == S_PEND) && !mreq && (stall_cnt_r != STALL_LIM)) begin
                stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // DMA byte capture and handshake; reset drops any captured byte
    always_ff @(posedge clock) begin
        if (reset) begin
            cap_addr_r <= 16'h0000;
            cap_data_r <= 8'h00;
            cap_last_r <= 1'b0;
            dma_ready  <= 1'b0;
        end else if (cep) begin
            dma_ready <= (state_r == S_IDLE) && dma_valid;
            if ((state_r == S_IDLE) && dma_valid) begin
                cap_addr_r <= dma_addr;
                cap_data_r <= dma_data;
                cap_last_r <= dma_last;
            end
        end
    end

    // I/O port registers; bank is only meaningful in banked mode
    always_ff @(posedge clock) begin
        if (reset) begin
            reg7f <= 8'h00;
            reg80 <= 5'b00110;
            bank  <= '0;
        end else if (cep) begin
            if (port7f_s) reg7f <= cpu_do;
            if (port80_s) reg80 <= cpu_do[5:1];
            if (mode != 2'd3) begin
                bank <= '0;
            end else if (portff_s) begin
                bank <= cpu_do[BW-1:0];
            end
        end
    end

    // Autostart address; dirset lasts a single clock even when cep is sparse
    always_ff @(posedge clock) begin
        if (reset) begin
            dir    <= 16'h0000;
            dirset <= 1'b0;
        end else begin
            dirset <= 1'b0;
            if (cep && (state_r == S_WRITE) && cap_last_r) begin
                dir    <= cap_addr_r + 16'd1;
                dirset <= 1'b1;
            end
        end
    end

    // CPU address translation by memory mode
    always_comb begin
        cpu_ram_a_s = '0;
        case (mode)
            2'd0:       cpu_ram_a_s = RAW'({a[14], a[12:0]});
            2'd1, 2'd2: cpu_ram_a_s = RAW'(a);
            2'd3: begin
                if (a[15:14] == 2'b11) begin
                    cpu_ram_a_s = {bank, a[13:0]};
                end else begin
                    cpu_ram_a_s = RAW'(a);
                end
            end
            default:    cpu_ram_a_s = RAW'(a);
        endcase
    end

    // RAM port mux: the DMA owns the port only during WRITE
    always_comb begin
        ram_a  = cpu_ram_a_s;
        ram_di = cpu_do;
        ram_we = cpu_wr_s && !reset;
        if (state_r == S_WRITE) begin
            ram_a  = RAW'(cap_addr_r);
            ram_di = cap_data_r;
            ram_we = !reset;
        end else begin
            ram_a  = cpu_ram_a_s;
        end
    end

endmodule

// File: tb/tb_lynx_mem_map.sv
// Directed bench for lynx_mem_map: port decodes, address mapping and DMA timing,
// with every RAM write matched against a queue of expected writes.
module tb_lynx_mem_map;

    logic        clock, reset, cep;
    logic [15:0] a;
    logic [7:0]  cpu_do;
    logic        mreq, iorq, wr;
    logic [1:0]  mode;
    logic        dma_valid, dma_ready, dma_last;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        wait_n;
    logic [15:0] ram_a;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic [7:0]  reg7f;
    logic [5:1]  reg80;
    logic [1:0]  bank;
    logic        rom_cs;
    logic [15:0] dir;
    logic        dirset;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    lynx_mem_map #(.BANKS(4), .STALL_MAX(15)) dut (
        .clock(clock), .reset(reset), .cep(cep), .a(a), .cpu_do(cpu_do),
        .mreq(mreq), .iorq(iorq), .wr(wr), .mode(mode),
        .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_data(dma_data),
        .dma_ready(dma_ready), .dma_last(dma_last), .wait_n(wait_n),
        .ram_a(ram_a), .ram_di(ram_di), .ram_we(ram_we),
        .reg7f(reg7f), .reg80(reg80), .bank(bank), .rom_cs(rom_cs),
        .dir(dir), .dirset(dirset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // scoreboard: every RAM write must match the oldest expected write
    always @(negedge clock) begin
        if (!reset && ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", {16'h0000, ram_a}, 32'hffff_ffff);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_addr", {16'h0000, ram_a}, {16'h0000, e.addr});
                check("sb_data", {24'h0, ram_di}, {24'h0, e.data});
            end
        end
    end

    task automatic port_out(input logic [15:0] addr, input logic [7:0] data);
        a = addr; cpu_do = data; iorq = 1'b0; wr = 1'b0;
        tick();
        iorq = 1'b1; wr = 1'b1;
    endtask

    task automatic dma_fast(input logic [15:0] addr, input logic [7:0] data, input logic last);
        logic [15:0] nxt;
        nxt = addr + 16'd1;
        dma_addr = addr; dma_data = data; dma_last = last; dma_valid = 1'b1;
        exp_q.push_back('{addr: addr, data: data});
        tick();
        dma_valid = 1'b0;
        check("dma_ready_pulse", {31'h0, dma_ready}, 32'h1);
        check("no_write_in_pend", {31'h0, ram_we}, 32'h0);
        tick();
        check("dma_ready_drop", {31'h0, dma_ready}, 32'h0);
        check("dma_we", {31'h0, ram_we}, 32'h1);
        check("dma_ram_a", {16'h0, ram_a}, {16'h0, addr});
        check("dma_ram_di", {24'h0, ram_di}, {24'h0, data});
        check("dma_wait_n", {31'h0, wait_n}, 32'h1);
        tick();
        check("dma_we_end", {31'h0, ram_we}, 32'h0);
        if (last) begin
            check("dirset_high", {31'h0, dirset}, 32'h1);
            check("dir_value", {16'h0, dir}, {16'h0, nxt});
            tick();
            check("dirset_one_clock", {31'h0, dirset}, 32'h0);
            check("dir_hold", {16'h0, dir}, {16'h0, nxt});
        end else begin
            check("dirset_idle", {31'h0, dirset}, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; cep = 1'b0; a = 16'h0000; cpu_do = 8'h00;
        mreq = 1'b1; iorq = 1'b1; wr = 1'b1; mode = 2'd0;
        dma_valid = 1'b0; dma_addr = 16'h0000; dma_data = 8'h00; dma_last = 1'b0;
        tick();
        tick();
        check("rst_reg7f", {24'h0, reg7f}, 32'h00);
        check("rst_reg80", {27'h0, reg80}, 32'h06);
        check("rst_bank", {30'h0, bank}, 32'h0);
        check("rst_dma_ready", {31'h0, dma_ready}, 32'h0);
        check("rst_dirset", {31'h0, dirset}, 32'h0);
        check("rst_dir", {16'h0, dir}, 32'h0);
        check("rst_wait_n", {31'h0, wait_n}, 32'h1);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        reset = 1'b0;

        // cep low: port write must not land
        port_out(16'h007f, 8'hab);
        check("cep_gate_reg7f", {24'h0, reg7f}, 32'h00);
        cep = 1'b1;

        // banked mode; OUT FFh also matches the 7F decode
        mode = 2'd3;
        port_out(16'h00ff, 8'h02);
        check("bank_set", {30'h0, bank}, 32'h2);
        check("ff_hits_7f", {24'h0, reg7f}, 32'h02);
        a = 16'hc005; cpu_do = 8'h5a; mreq = 1'b0; wr = 1'b0;
        exp_q.push_back('{addr: 16'h8005, data: 8'h5a});
        #1;
        check("bank_ram_a", {16'h0, ram_a}, 32'h8005);
        check("bank_ram_we", {31'h0, ram_we}, 32'h1);
        check("bank_ram_di", {24'h0, ram_di}, 32'h5a);
        tick();
        mreq = 1'b1; wr = 1'b1;

        // 48K mode
        mode = 2'd0;
        a = 16'h6123; cpu_do = 8'h11; mreq = 1'b0; wr = 1'b0;
        exp_q.push_back('{addr: 16'h2123, data: 8'h11});
        #1;
        check("m0_ram_a", {16'h0, ram_a}, 32'h2123);
        tick();
        wr = 1'b1; a = 16'h0100;
        #1;
        check("bank_cleared", {30'h0, bank}, 32'h0);
        check("rom_cs_low", {31'h0, rom_cs}, 32'h1);
        check("rom_read_no_we", {31'h0, ram_we}, 32'h0);
        a = 16'h4000;
        #1;
        check("rom_cs_m0_4000", {31'h0, rom_cs}, 32'h0);
        mode = 2'd1;
        #1;
        check("rom_cs_m1_4000", {31'h0, rom_cs}, 32'h1);
        mreq = 1'b1;
        port_out(16'h007f, 8'h10);
        check("reg7f_10", {24'h0, reg7f}, 32'h10);
        a = 16'h0100; mreq = 1'b0;
        #1;
        check("rom_cs_masked", {31'h0, rom_cs}, 32'h0);
        mreq = 1'b1;
        port_out(16'h0080, 8'h3e);
        check("reg80_1f", {27'h0, reg80}, 32'h1f);
        port_out(16'h007f, 8'h00);
        mode = 2'd0;

        // DMA with the bus free
        dma_fast(16'h1000, 8'h33, 1'b0);

        // DMA with the CPU holding the bus: stall then steal
        a = 16'h8000; mreq = 1'b0;
        dma_addr = 16'h2000; dma_data = 8'h44; dma_last = 1'b0; dma_valid = 1'b1;
        exp_q.push_back('{addr: 16'h2000, data: 8'h44});
        tick();
        dma_valid = 1'b0;
        check("stall_ready", {31'h0, dma_ready}, 32'h1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("stall_wait_n", {31'h0, wait_n}, 32'h1);
            check("stall_no_we", {31'h0, ram_we}, 32'h0);
        end
        tick();
        check("steal_wait_n", {31'h0, wait_n}, 32'h0);
        tick();
        check("steal_release", {31'h0, wait_n}, 32'h1);
        check("steal_we", {31'h0, ram_we}, 32'h1);
        check("steal_ram_a", {16'h0, ram_a}, 32'h2000);
        tick();
        check("steal_we_end", {31'h0, ram_we}, 32'h0);
        mreq = 1'b1;

        // last byte: autostart address with and without wrap
        dma_fast(16'h1233, 8'h99, 1'b1);
        dma_fast(16'hffff, 8'h55, 1'b1);

        // reset while PEND abandons the byte
        port_out(16'h0080, 8'h3e);
        mreq = 1'b0;
        dma_addr = 16'h3000; dma_data = 8'h66; dma_last = 1'b0; dma_valid = 1'b1;
        tick();
        dma_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mreq = 1'b1;
        check("rst_mid_reg80", {27'h0, reg80}, 32'h06);
        check("rst_mid_wait_n", {31'h0, wait_n}, 32'h1);
        check("rst_mid_no_we", {31'h0, ram_we}, 32'h0);
        tick();
        tick();
        check("rst_mid_idle_no_we", {31'h0, ram_we}, 32'h0);
        dma_fast(16'h3000, 8'h77, 1'b0);

        tick();
        check("sb_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
